pc_fetch: RTL and testbench

Instruction fetch stage for the MIPS core. It holds the program counter and fetches instructions over a request/acknowledge handshake with instruction memory. Each fetched word is presented to the control decoder (opcode) and to the datapath, and the PC advances only when the datapath signals completion. Next-PC selection consumes the control unit's branch/jump outputs and the ALU zero flag, so this block sits both directly upstream (supplies the opcode) and downstream (consumes PC-select signals) of control decode.

---
 rtl/pc_fetch.sv | 98 +++++++++
 tb/tb_pc_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the fetched word for decode/execute and commits the next PC on exec_done.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        mux_pc_branch,
  input  logic        mux_branch_jump,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FAULT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               last_wait;
  logic               br_taken;
  logic [31:0]        br_offset;
  logic [31:0]        jump_target;
  logic [31:0]        next_pc;

  // The current FETCH cycle is the T-th one without an ack.
  assign last_wait = (wait_cnt == CNT_W'(TIMEOUT - 1));

  assign pc_plus4    = pc + 32'd4;
  assign br_taken    = branch & mux_pc_branch & alu_zero;
  assign br_offset   = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    if (!mux_branch_jump) next_pc = jump_target;
    else if (br_taken)    next_pc = pc_plus4 + br_offset;
    else                  next_pc = pc_plus4;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ack)       state_nxt = ISSUE;
        else if (last_wait) state_nxt = FAULT;
      end
      ISSUE: if (exec_done) state_nxt = FETCH;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == ISSUE);
    fetch_err   = (state == FAULT);
  end

  // Ack takes priority over the timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == FETCH && !imem_ack && !last_wait) wait_cnt <= wait_cnt + 1'b1;
      else                                           wait_cnt <= '0;
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (state == ISSUE && exec_done) pc <= next_pc;
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized
// instruction streams against an arithmetic next-PC reference model.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        exec_done;
  logic        branch;
  logic        mux_pc_branch;
  logic        mux_branch_jump;
  logic        alu_zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  pc_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch(branch), .mux_pc_branch(mux_pc_branch),
    .mux_branch_jump(mux_branch_jump), .alu_zero(alu_zero),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] r_word;
  logic [3:0]  r_ctl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS next-PC rules expressed as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic br, input logic mpb,
                                             input logic mbj, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (!mbj) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    off = int'(word & 32'h0000_FFFF);
    if (off >= 32768) off = off - 65536;
    if (br && mpb && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    branch = 1'b0; mux_pc_branch = 1'b0; mux_branch_jump = 1'b1; alu_zero = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc, RESET_PC);
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_opcode", {26'b0, opcode}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    clear_inputs();
    repeat (cycles) tick();
    check_reset_values();
    rst = 1'b0;
    m_pc = RESET_PC;
    tick();
    check("req_after_reset", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 16 && imem_req !== 1'b1; i++) tick();
    check("req_wait", {31'b0, imem_req}, 32'd1);
  endtask

  // Serve one fetch after `delay` wait cycles; optionally pulse exec_done while waiting.
  task automatic fetch(input logic [31:0] word, input int delay, input bit poke_exec);
    wait_req();
    check("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < delay; i++) begin
      exec_done  = poke_exec;
      imem_rdata = $urandom;
      tick();
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("pc_hold_fetch", pc, m_pc);
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    m_instr  = word;
    check("valid", {31'b0, instr_valid}, 32'd1);
    check("req_drop", {31'b0, imem_req}, 32'd0);
    check("instr", instr, word);
    check("opcode", {26'b0, opcode}, word >> 26);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
  endtask

  // Hold ISSUE for `idle` cycles with stray acks and noisy controls, then commit.
  task automatic execute(input logic br, input logic mpb, input logic mbj, input logic z,
                         input int idle);
    for (int i = 0; i < idle; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~m_instr;
      {branch, mux_pc_branch, mux_branch_jump, alu_zero} = 4'($urandom);
      tick();
      check("valid_hold", {31'b0, instr_valid}, 32'd1);
      check("instr_hold", instr, m_instr);
      check("pc_hold_issue", pc, m_pc);
    end
    imem_ack = 1'b0;
    branch = br; mux_pc_branch = mpb; mux_branch_jump = mbj; alu_zero = z;
    exec_done = 1'b1;
    tick();
    clear_inputs();
    m_pc = model_next(m_pc, m_instr, br, mpb, mbj, z);
    check("next_pc", pc, m_pc);
    check("req_next", {31'b0, imem_req}, 32'd1);
    check("addr_next", imem_addr, m_pc);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Sequential fetch from reset: addresses 0, 4, 8.
    do_reset(2);
    fetch(32'h0000_0020, 0, 1'b0);
    check("first_pc_plus4", pc_plus4, 32'h4);
    execute(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("seq_pc_4", pc, 32'h4);
    fetch(32'h0000_0020, 0, 1'b0);
    execute(1'b0, 1'b0, 1'b1, 1'b0, 1);
    check("seq_pc_8", pc, 32'h8);

    // BEQ offset 3 taken from 8, then not taken.
    fetch(32'h1000_0003, 0, 1'b0);
    execute(1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("br_taken", pc, 32'h18);
    fetch(32'h1000_0003, 0, 1'b0);
    execute(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("br_not_taken", pc, 32'h1C);

    // Backward branches and address wrap.
    do_reset(1);
    fetch(32'h1000_FFFE, 0, 1'b0);
    execute(1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("br_back_wrap", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0020, 1, 1'b0);
    execute(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("seq_wrap", pc, 32'h0);
    fetch(32'h1000_FFFF, 0, 1'b0);
    execute(1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("br_self", pc, 32'h0);
    fetch(32'h1000_FFFD, 0, 1'b0);
    execute(1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("br_back", pc, 32'hFFFF_FFF8);

    // Jump keeps pc_plus4[31:28].
    fetch(32'h0800_0010, 0, 1'b0);
    execute(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("jump", pc, 32'hF000_0040);

    // Ack on the last allowed cycle, with exec_done pulsed during FETCH.
    fetch(32'h2000_1234, TIMEOUT - 1, 1'b1);
    execute(1'b1, 1'b0, 1'b1, 1'b1, 2);

    // Randomized instruction stream.
    for (int n = 0; n < 24; n++) begin
      r_word = $urandom;
      r_ctl  = 4'($urandom);
      fetch(r_word, int'($urandom_range(0, TIMEOUT - 1)), 1'($urandom));
      execute(r_ctl[3], r_ctl[2], r_ctl[1] | r_ctl[0], $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 2)));
    end

    // Mid-fetch reset: ack in the reset cycle is discarded.
    wait_req();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    do_reset(1);

    // Timeout: T FETCH cycles without ack enter FAULT.
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      check("to_req", {31'b0, imem_req}, 32'd1);
      check("to_err", {31'b0, fetch_err}, 32'd0);
    end
    tick();
    check("fault_err", {31'b0, fetch_err}, 32'd1);
    check("fault_req", {31'b0, imem_req}, 32'd0);
    check("fault_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; exec_done = 1'b1;
    repeat (3) tick();
    check("fault_sticky", {31'b0, fetch_err}, 32'd1);
    check("fault_req_low", {31'b0, imem_req}, 32'd0);

    // Recovery from FAULT only through reset.
    do_reset(1);
    fetch(32'h0000_0020, 0, 1'b0);
    execute(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("recover_pc", pc, RESET_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
